// File: rtl/rgb_channel_serializer.sv
// rgb_channel_serializer
//   Buffers packed 24-bit RGB pixels in a DEPTH-entry FIFO and emits each one
//   as three consecutive 8-bit channel samples (R, G, B). Feeds the 8-bit
//   integer input of the int-to-float converter directly.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   pix_valid/ready   upstream pixel handshake
//   pix_data[23:0]    {R, G, B}
//   pix_last          pixel ends its frame
//   ch_valid/ready    downstream sample handshake
//   ch_data[7:0]      channel byte, passed through unmodified
//   ch_sel[1:0]       0=R, 1=G, 2=B
//   ch_last           B sample of a pixel tagged pix_last
//   fifo_count[CW-1:0] pixels held, including the head being serialized
module rgb_channel_serializer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic [23:0]   pix_data,
  input  logic          pix_last,
  output logic          ch_valid,
  input  logic          ch_ready,
  output logic [7:0]    ch_data,
  output logic [1:0]    ch_sel,
  output logic          ch_last,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        last;
    logic [23:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    S_R = 2'd0,
    S_G = 2'd1,
    S_B = 2'd2
  } state_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  state_t          state, state_nxt;
  logic            push, pop, fire;

  // Ready comes only from the registered count: no bypass when full.
  assign pix_ready = (fifo_count != CW'(DEPTH));
  assign ch_valid  = (fifo_count != '0);
  // rst_n gating keeps pushes during reset out of storage as well.
  assign push      = pix_valid && pix_ready && rst_n;
  assign fire      = ch_valid && ch_ready;
  assign pop       = fire && (state == S_B);
  assign head      = mem[rd_ptr];
  assign ch_sel    = state;

  // Storage has no reset; its content is don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{last: pix_last, data: pix_data};
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_R;
    else        state <= state_nxt;
  end

  // Channel sequencing; advances only on a sample handshake, so a stall
  // holds state, head and every ch_* output.
  always_comb begin
    state_nxt = state;
    ch_data   = head.data[23:16];
    ch_last   = 1'b0;
    case (state)
      S_R: begin
        if (fire) state_nxt = S_G;
      end
      S_G: begin
        ch_data = head.data[15:8];
        if (fire) state_nxt = S_B;
      end
      S_B: begin
        ch_data = head.data[7:0];
        ch_last = head.last;
        if (fire) state_nxt = S_R;
      end
      default: state_nxt = S_R;
    endcase
  end

endmodule

// File: doc/rgb_channel_serializer.md
# rgb_channel_serializer

Front-end stage of the RGB float path: accepts packed 24-bit RGB pixels over a valid/ready handshake and buffers them in a small FIFO. It emits each pixel as three consecutive 8-bit unsigned channel samples (R, G, B), with a channel tag and an end-of-frame marker. Its `ch_data` output drives the 8-bit integer input of the combinational int-to-float converter directly. Downstream backpressure propagates to the pixel source through the FIFO.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO depth in pixels; power of two, 2..16.
- `CW`, default $clog2(DEPTH)+1: width of `fifo_count`; derived, do not override.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `pix_valid` input 1: upstream pixel valid.
- `pix_ready` output 1: FIFO can accept a pixel.
- `pix_data` input 24: packed pixel; [23:16]=R, [15:8]=G, [7:0]=B.
- `pix_last` input 1: pixel is the last of its frame.
- `ch_valid` output 1: channel sample valid.
- `ch_ready` input 1: downstream accepts the sample.
- `ch_data` output 8: unsigned channel value, 0..255.
- `ch_sel` output 2: channel tag; 0=R, 1=G, 2=B. Value 3 is never driven.
- `ch_last` output 1: high only on the B sample of a pixel written with `pix_last`=1.
- `fifo_count` output CW: number of pixels held, 0..DEPTH. Includes the head pixel being serialized.

## Operation
- FIFO storage: DEPTH entries of {last, data[23:0]}, with wrapping read and write pointers and a registered count.
- Push: occurs when `pix_valid && pix_ready`. `pix_ready` = (`fifo_count` != DEPTH), combinational from the registered count.
- Serializer FSM: states S_R, S_G, S_B. Reset state is S_R.
  - `ch_valid` = (`fifo_count` != 0).
  - `ch_sel` = state encoding.
  - `ch_data` = the head entry's byte selected by state.
  - `ch_last` = head.last && (state == S_B).
- Transitions occur only on `ch_valid && ch_ready`: S_R→S_G, S_G→S_B, S_B→S_R. The S_B→S_R transition pops the head entry.
- Stall: with `ch_valid && !ch_ready`, state, head, and all ch_* outputs hold unchanged.
- Simultaneous push and pop in the same cycle: both occur and the count is unchanged.
  - When full, `pix_ready`=0 even if a pop is occurring; there is no bypass.
  - When empty, the pushed pixel is not visible until the next cycle; there is no fall-through.
- Pointer wrap: pointers wrap from DEPTH-1 to 0, with no gap in ordering.
- Data path: channel bytes pass through unmodified; no arithmetic. Values 0 and 255 are passed as-is; zero handling is the converter's responsibility.
- Pushes while `rst_n` is low are ignored.
- Reset mid-pixel (e.g. in state S_G) discards the partially emitted pixel and all queued pixels. After release, output restarts from S_R on the next pushed pixel.

## Timing
- Reset values: `pix_ready`=1, `ch_valid`=0, `ch_sel`=0, `ch_last`=0, `fifo_count`=0. `ch_data` = storage content of entry 0, treated as don't-care while `ch_valid`=0.
- Latency: a pixel pushed at rising edge N into an empty FIFO gives `ch_valid`=1, R at sel 0, during cycle N+1.
  - With `ch_ready` held high, G appears in cycle N+2 and B in cycle N+3.
  - The entry is popped at the edge ending cycle N+3.
- Throughput: one pixel per 3 cycles sustained, i.e. one channel sample per cycle with no bubbles between pixels when the FIFO is non-empty.
- `pix_ready` deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the B-sample pop.
- All outputs change only on the rising edge of `clk` or the falling edge of `rst_n`.

## Test plan
- Single pixel: push 0xFF8000 with last=1, `ch_ready` held 1 → cycles N+1..N+3 show (data,sel,last) = (0xFF,0,0), (0x80,1,0), (0x00,2,1); then `ch_valid`=0 and `fifo_count`=0.
- Backpressure: push 0x123456; hold `ch_ready`=0 for 5 cycles with sel=1 presented → 0x34/sel 1 is held stable throughout; after release, 0x56/sel 2 follows and `fifo_count` returns to 0.
- Fill/wrap: with DEPTH=4 and `ch_ready`=0, push 4 pixels → `pix_ready`=0 and `fifo_count`=4. Continue alternating pushes until pointers have wrapped twice → 18+ pixels emerge in order with no loss or duplication.
- Simultaneous push/pop: with count=2, push on the same edge as a B-sample handshake → count stays 2, `pix_ready` stays 1, ordering is preserved.
- Reset mid-pixel: 3 pixels queued with state S_G; assert `rst_n`=0 asynchronously mid-cycle → outputs reach reset values immediately. After release, push 0x0A0B0C → outputs 0x0A, 0x0B, 0x0C only.
- Boundary values: push 0x000000 and 0xFFFFFF back-to-back → samples 00,00,00,FF,FF,FF are emitted in 6 consecutive cycles, `ch_last` low unless last was set.
